yuv422_byte_packer: RTL
=======================

YUV422_BYTE_PACKER -- requirements
Module: yuv422_byte_packer

Interface
REQ-001 SHALL have parameter ORDER, default 0, byte order: 0 = YUYV (Y1,U,Y2,V), 1 = UYVY (U,Y1,V,Y2).
REQ-002 SHALL have parameter LINE_PAIRS, default 320, pixel pairs per video line (legal range 1..4095).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream pixel pair present.
REQ-006 SHALL have port in_ready  output  1  block can accept a pair this cycle.
REQ-007 SHALL have ports in_y1, in_y2, in_u, in_v  input  8 each  one YUV422 pixel pair (shared U/V).
REQ-008 SHALL have port out_data  output  8  serialized byte.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts byte.
REQ-011 SHALL have port out_sol  output  1  qualifies first byte of a line.
REQ-012 SHALL have port out_eol  output  1  qualifies last byte of a line.

Function
REQ-013 SHALL accept a pair on a cycle with in_valid and in_ready both high, capturing all four inputs into a 2-entry FIFO (32 bits per entry).
REQ-014 SHALL drive in_ready = (FIFO occupancy < 2), from registered state only, with no combinational path from out_ready or in_valid.
REQ-015 SHALL drive out_valid high exactly when FIFO occupancy > 0.
REQ-016 SHALL serialize the FIFO head through states B0, B1, B2, B3, advancing one state per out_valid and out_ready handshake, B3 returning to B0.
REQ-017 SHALL output bytes per ORDER: YUYV = B0:Y1, B1:U, B2:Y2, B3:V; UYVY = B0:U, B1:Y1, B2:V, B3:Y2.
REQ-018 SHALL pop the FIFO head on the B3 handshake.
REQ-019 SHALL hold out_data, out_sol and out_eol stable while out_valid is high and out_ready is low.
REQ-020 SHALL drive out_data = 0, out_sol = 0, out_eol = 0 whenever out_valid is low.
REQ-021 SHALL present the first byte of a pair pushed into an empty FIFO one cycle after acceptance (latency 1).
REQ-022 SHALL sustain throughput of one byte per cycle with out_ready held high, and one pair per 4 cycles in steady state.
REQ-023 SHALL handle simultaneous push and B3 pop in one cycle, leaving occupancy unchanged, with no data loss or duplication.
REQ-024 SHALL keep a pair counter 0..LINE_PAIRS-1, incremented on each pop and wrapping to 0 after LINE_PAIRS-1.
REQ-025 SHALL assert out_sol in state B0 when the pair counter is 0.
REQ-026 SHALL assert out_eol in state B3 when the pair counter is LINE_PAIRS-1.
REQ-027 SHALL, when LINE_PAIRS = 1, assert out_sol and out_eol on every pair (B0 and B3 respectively).

Reset
REQ-028 SHALL, on rst high at a clock edge, clear FIFO occupancy and pointers, set state to B0 and pair counter to 0, and drive out_valid 0 and in_ready 1 on the following cycle.
REQ-029 SHALL, if reset occurs mid-pair or mid-line, discard buffered pairs and emit nothing from them, so the next accepted pair starts a fresh line with out_sol.
REQ-030 SHALL ignore in_valid while rst is high.

Structure
REQ-031 SHALL place the ORDER_YUYV/ORDER_UYVY constants, the B0..B3 state encoding and the pair-counter width constant (12) in shared package yuv422_pkg.
REQ-032 SHALL implement the 2-entry buffer as sub-module sync_fifo2 (parameterized width, occupancy count, push/pop, full/empty), with the byte FSM and line counter at top level.

Verification
REQ-033 SHALL verify single pair with ORDER=0: Y1=0x10, U=0x80, Y2=0x20, V=0x90, out_ready=1 -> bytes 10,80,20,90 on 4 consecutive cycles starting 1 cycle after acceptance.
REQ-034 SHALL verify the same pair with ORDER=1 -> bytes 80,10,90,20.
REQ-035 SHALL verify back-pressure: out_ready=0 for 5 cycles at B1, with 3 pairs offered back-to-back -> in_ready drops after 2 accepted, B1 byte held stable, no loss; all 12 bytes delivered in order.
REQ-036 SHALL verify framing with LINE_PAIRS=3 and 7 pairs streamed -> out_sol on bytes 0, 12, 24; out_eol on bytes 11, 23; no eol on byte 27.
REQ-037 SHALL verify reset mid-pair: rst pulsed while in state B2 with 1 pair queued -> out_valid 0 next cycle, queued pair never emitted, next pair yields out_sol on its B0.
REQ-038 SHALL verify random in_valid/out_ready at 50% density over 10000 pairs -> byte stream matches a reference model exactly, with no protocol violations.

Source files
------------

// File: rtl/yuv422_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | yuv422_pkg : shared constants and types for the YUV422 byte packer  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package yuv422_pkg;

   localparam int ORDER_YUYV = 0;
   localparam int ORDER_UYVY = 1;
   localparam int PAIR_CNT_W = 12;

   typedef enum logic [1:0] {
      B0 = 2'd0,
      B1 = 2'd1,
      B2 = 2'd2,
      B3 = 2'd3
   } byte_state_t;

   typedef struct packed {
      logic [7:0] y1;
      logic [7:0] u;
      logic [7:0] y2;
      logic [7:0] v;
   } pair_t;

endpackage
`default_nettype wire

// File: rtl/yuv422_byte_packer_sync_fifo2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync_fifo2 : two-entry synchronous FIFO with occupancy count        |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module sync_fifo2 #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic [1:0]       count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] r_mem [2];
   logic             r_wr_ptr;
   logic             r_rd_ptr;
   logic [1:0]       r_count;
   logic             w_push;
   logic             w_pop;

   // Requests are qualified here so a caller can never overrun or underrun.
   assign w_push   = push & ~full;
   assign w_pop    = pop & ~empty;
   assign full     = (r_count == 2'd2);
   assign empty    = (r_count == 2'd0);
   assign count    = r_count;
   assign pop_data = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/yuv422_byte_packer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | yuv422_byte_packer : serializes YUV422 pixel pairs into a byte      |
// | stream with start/end-of-line flags.  Rev 1.0                       |
// +--------------------------------------------------------------------+
module yuv422_byte_packer
   import yuv422_pkg::*;
#(
   parameter int ORDER      = 0,
   parameter int LINE_PAIRS = 320
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_y1,
   input  logic [7:0] in_y2,
   input  logic [7:0] in_u,
   input  logic [7:0] in_v,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_sol,
   output logic       out_eol
);

   localparam logic [PAIR_CNT_W-1:0] c_last_pair = PAIR_CNT_W'(LINE_PAIRS - 1);

   byte_state_t            r_state;
   byte_state_t            w_state_nxt;
   logic [PAIR_CNT_W-1:0]  r_pair_cnt;
   pair_t                  w_in_pair;
   pair_t                  w_head;
   logic [1:0]             w_count;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_hs;
   logic                   w_pop;
   logic [7:0]             w_lane [4];
   logic [7:0]             w_byte;

   assign w_in_pair = '{y1: in_y1, u: in_u, y2: in_y2, v: in_v};
   assign in_ready  = ~w_full;
   assign out_valid = ~w_empty;
   assign w_push    = in_valid & in_ready & ~rst;
   assign w_hs      = out_ready & (w_count != 2'd0);
   assign w_pop     = w_hs & (r_state == B3);

   sync_fifo2 #(
      .WIDTH ($bits(pair_t))
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (w_push),
      .push_data (w_in_pair),
      .pop       (w_pop),
      .pop_data  (w_head),
      .count     (w_count),
      .full      (w_full),
      .empty     (w_empty)
   );

   generate
      if (ORDER == ORDER_UYVY) begin : g_uyvy
         assign w_lane[0] = w_head.u;
         assign w_lane[1] = w_head.y1;
         assign w_lane[2] = w_head.v;
         assign w_lane[3] = w_head.y2;
      end else begin : g_yuyv
         assign w_lane[0] = w_head.y1;
         assign w_lane[1] = w_head.u;
         assign w_lane[2] = w_head.y2;
         assign w_lane[3] = w_head.v;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= B0;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_byte      = w_lane[0];
      case (r_state)
         B0: begin
            w_byte = w_lane[0];
            if (w_hs) w_state_nxt = B1;
         end
         B1: begin
            w_byte = w_lane[1];
            if (w_hs) w_state_nxt = B2;
         end
         B2: begin
            w_byte = w_lane[2];
            if (w_hs) w_state_nxt = B3;
         end
         B3: begin
            w_byte = w_lane[3];
            if (w_hs) w_state_nxt = B0;
         end
         default: w_state_nxt = B0;
      endcase
      // All outputs decode registered state, so they hold while stalled.
      out_data = out_valid ? w_byte : 8'd0;
      out_sol  = out_valid && (r_state == B0) && (r_pair_cnt == '0);
      out_eol  = out_valid && (r_state == B3) && (r_pair_cnt == c_last_pair);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pair_cnt <= '0;
      end else if (w_pop) begin
         r_pair_cnt <= (r_pair_cnt == c_last_pair) ? '0 : r_pair_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire
